// File: rtl/branch_predictor_bht.sv
// Bimodal branch predictor: PC-indexed saturating-counter table, DEC lookup,
// single-entry DEC->EXE branch record, EXE resolve/redirect and perf counters.
module branch_predictor_bht #(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned RESET_CTR = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             dec_valid,
  input  logic [31:0]      dec_pc,
  input  logic [31:0]      dec_target,
  input  logic             stall,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             exe_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(RESET_CTR);
  localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [CTR_BITS-1:0] cur_ctr;
  logic [CTR_BITS-1:0] upd_ctr_d;

  logic        exe_v_q;
  logic        exe_pred_q;
  logic [31:0] exe_pc_q;
  logic [31:0] exe_tgt_q;

  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] exe_idx;
  logic             upd_en;

  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] br_count_d;
  logic [CNT_W-1:0] mispred_count_q;
  logic [CNT_W-1:0] mispred_count_d;

  assign dec_idx = dec_pc[IDX_W+1:2];
  assign exe_idx = exe_pc_q[IDX_W+1:2];

  // DEC lookup: zero-latency read of the pre-update counter, no bypass
  always_comb begin
    pred_taken  = table_q[dec_idx][CTR_BITS-1];
    pred_target = pred_taken ? dec_target : dec_pc + 32'd4;
  end

  // EXE resolve: compare actual outcome against the stored prediction
  always_comb begin
    mispredict  = exe_v_q & (exe_taken ^ exe_pred_q);
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = exe_taken ? exe_tgt_q : exe_pc_q + 32'd4;
    end
  end

  // Saturating counter step and saturating perf-count increments
  always_comb begin
    upd_en          = exe_v_q & ~stall;
    cur_ctr         = table_q[exe_idx];
    upd_ctr_d       = cur_ctr;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (exe_taken) begin
      if (cur_ctr != CTR_MAX) upd_ctr_d = cur_ctr + CTR_BITS'(1);
    end else begin
      if (cur_ctr != '0) upd_ctr_d = cur_ctr - CTR_BITS'(1);
    end
    if (upd_en) begin
      if (br_count_q != CNT_MAX) br_count_d = br_count_q + CNT_W'(1);
      if (mispredict && (mispred_count_q != CNT_MAX)) begin
        mispred_count_d = mispred_count_q + CNT_W'(1);
      end
    end
  end

  // Counter table: reinitialised on reset, one entry written per resolved branch
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RST;
    end else if (upd_en) begin
      table_q[exe_idx] <= upd_ctr_d;
    end
  end

  // DEC->EXE record: held on stall, wrong-path DEC branch squashed on mispredict
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      exe_v_q    <= 1'b0;
      exe_pred_q <= 1'b0;
      exe_pc_q   <= '0;
      exe_tgt_q  <= '0;
    end else if (!stall) begin
      exe_v_q    <= dec_valid & ~mispredict;
      exe_pred_q <= pred_taken;
      exe_pc_q   <= dec_pc;
      exe_tgt_q  <= dec_target;
    end
  end

  // Perf counter registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule
